// File: rtl/hex_display_scanner_pkg.sv
// Shared types and segment codes for the 7-segment scanner.
// Segment codes are active-low, bit0=a .. bit6=g, bit7=dp.
package hex_display_scanner_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index 0 is the rightmost entry.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,
        8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99,
        8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef struct packed {
        logic [3:0] data;
        logic       dp;
        logic       show;
        logic       blink;
    } digit_t;

    typedef enum logic {
        CTL_IDLE,
        CTL_CLEAR
    } ctl_state_t;

    typedef enum logic {
        SCAN_BLANK,
        SCAN_SHOW
    } scan_state_t;

endpackage

// File: rtl/hex_display_scanner_hex_to_seg.sv
// Combinational hex digit + decimal point to active-low segments.
// Shared with other display glue.
module hex_to_seg
    import hex_display_scanner_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg_n
);

    logic [7:0] code;

    assign code  = HEX_SEG[hex];
    assign seg_n = {code[7] & ~dp, code[6:0]};

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed 7-segment scanner with per-digit register file,
// blanking gap between digits, per-digit blink and bulk clear.
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 250
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  wr_show,
    input  logic                  wr_blink,
    output logic                  wr_err,
    input  logic                  clr_req,
    output logic                  busy,
    output logic [7:0]            seg_n,
    output logic [NUM_DIGITS-1:0] dig_en
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] BLK_LAST   = PW'(BLANK_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

    digit_t                  ent [NUM_DIGITS];
    digit_t                  cur;
    ctl_state_t              ctl;
    scan_state_t             scan_st;
    logic [PW-1:0]           pre;
    logic [BW-1:0]           blink_cnt;
    logic                    phase;
    logic [2:0]              idx;
    logic [2:0]              clr_ptr;
    logic [7:0]              cur_seg;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    wrap;
    logic                    accept;
    logic                    addr_ok;
    logic                    visible;

    always_comb begin
        cur    = '0;
        onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                cur       = ent[i];
                onehot[i] = 1'b1;
            end
        end
    end

    hex_to_seg u_dec (
        .hex   (cur.data),
        .dp    (cur.dp),
        .seg_n (cur_seg)
    );

    assign wrap     = (pre == PRE_LAST);
    assign wr_ready = RESET_N && (ctl == CTL_IDLE) && !clr_req;
    assign accept   = wr_valid && wr_ready;
    assign addr_ok  = (32'(wr_addr) < NUM_DIGITS);
    assign busy     = (ctl == CTL_CLEAR);
    assign visible  = cur.show && !(cur.blink && phase);

    // Scan sequencing and registered pin drive
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pre       <= '0;
            idx       <= '0;
            scan_st   <= SCAN_BLANK;
            blink_cnt <= '0;
            phase     <= 1'b0;
            seg_n     <= SEG_BLANK;
            dig_en    <= '0;
        end else begin
            pre <= wrap ? '0 : pre + 1'b1;
            if (wrap) begin
                scan_st <= SCAN_BLANK;
                idx     <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else if (scan_st == SCAN_BLANK && pre == BLK_LAST) begin
                scan_st <= SCAN_SHOW;
            end
            if (scan_st == SCAN_SHOW) begin
                dig_en <= onehot;
                seg_n  <= visible ? cur_seg : SEG_BLANK;
            end else begin
                dig_en <= '0;
                seg_n  <= SEG_BLANK;
            end
        end
    end

    // Register file ownership: host writes or sequential clear
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            ctl     <= CTL_IDLE;
            clr_ptr <= '0;
            wr_err  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) ent[i] <= '0;
        end else begin
            wr_err <= accept && !addr_ok;
            unique case (ctl)
                CTL_IDLE: begin
                    if (clr_req) begin
                        ctl     <= CTL_CLEAR;
                        clr_ptr <= '0;
                    end else if (accept && addr_ok) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (wr_addr == 3'(i))
                                ent[i] <= '{wr_data, wr_dp, wr_show, wr_blink};
                        end
                    end
                end
                CTL_CLEAR: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (clr_ptr == 3'(i)) ent[i] <= '0;
                    end
                    if (clr_ptr == IDX_LAST) ctl <= CTL_IDLE;
                    else clr_ptr <= clr_ptr + 3'd1;
                end
                default: ctl <= CTL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized bench for hex_display_scanner against a slot-arithmetic model.
// Model derives scan position from cycle count since reset release.
module tb_hex_display_scanner;

    localparam int N     = 6;
    localparam int TICK  = 8;
    localparam int BLANK = 2;
    localparam int BLINK = 2;

    logic         CLOCK_50 = 1'b0;
    logic         RESET_N  = 1'b0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [2:0]   wr_addr  = '0;
    logic [3:0]   wr_data  = '0;
    logic         wr_dp    = 1'b0;
    logic         wr_show  = 1'b0;
    logic         wr_blink = 1'b0;
    logic         wr_err;
    logic         clr_req  = 1'b0;
    logic         busy;
    logic [7:0]   seg_n;
    logic [N-1:0] dig_en;

    hex_display_scanner #(
        .NUM_DIGITS   (N),
        .TICK_DIV     (TICK),
        .BLANK_CYCLES (BLANK),
        .BLINK_DIV    (BLINK)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_dp    (wr_dp),
        .wr_show  (wr_show),
        .wr_blink (wr_blink),
        .wr_err   (wr_err),
        .clr_req  (clr_req),
        .busy     (busy),
        .seg_n    (seg_n),
        .dig_en   (dig_en)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [7:0] hexseg [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Model: {data[3:0], dp, show, blink} per digit
    logic [6:0] m [N];
    int         k;
    int         clr_left;
    int         n_chk;
    int         n_pass;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, obs, exp, k);
    endtask

    function automatic void exp_out(input int kk, output logic [7:0] s,
                                    output logic [N-1:0] d);
        int p, slot, di, ph;
        logic [6:0] e;
        p    = kk % TICK;
        slot = kk / TICK;
        di   = slot % N;
        ph   = (slot / BLINK) % 2;
        s    = 8'hFF;
        d    = '0;
        if (kk > 0 && ((kk - 1) % TICK) >= BLANK) begin
            p    = (kk - 1) % TICK;
            slot = (kk - 1) / TICK;
            di   = slot % N;
            ph   = (slot / BLINK) % 2;
            e    = m[di];
            d    = N'(1) << di;
            if (e[1] && !(e[0] && ph == 1)) begin
                s = hexseg[e[6:3]];
                if (e[2]) s[7] = 1'b0;
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m[i] = '0;
        k        = 0;
        clr_left = 0;
    endtask

    task automatic step();
        logic [7:0]   es;
        logic [N-1:0] ed;
        logic         acc;
        logic         eerr;
        #1;
        chk("wr_ready", 32'(wr_ready),
            32'((clr_left == 0) && !clr_req));
        chk("busy", 32'(busy), 32'(clr_left > 0));
        acc = wr_valid && (clr_left == 0) && !clr_req;
        @(posedge CLOCK_50);
        k++;
        exp_out(k, es, ed);
        eerr = 1'b0;
        if (clr_left > 0) begin
            m[N - clr_left] = '0;
            clr_left--;
        end else if (clr_req) begin
            clr_left = N;
        end else if (acc) begin
            if (int'(wr_addr) < N)
                m[wr_addr] = {wr_data, wr_dp, wr_show, wr_blink};
            else
                eerr = 1'b1;
        end
        #1;
        chk("seg_n", 32'(seg_n), 32'(es));
        chk("dig_en", 32'(dig_en), 32'(ed));
        chk("wr_err", 32'(wr_err), 32'(eerr));
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] dt,
                      input logic dp, input logic sh, input logic bl);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = dt;
        wr_dp    = dp;
        wr_show  = sh;
        wr_blink = bl;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        RESET_N  = 1'b0;
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        #1;
        chk("rst_seg", 32'(seg_n), 32'hFF);
        chk("rst_dig", 32'(dig_en), 32'h0);
        chk("rst_ready", 32'(wr_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(wr_err), 32'h0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0]   es;
        logic [N-1:0] ed;
        bit           lit;
        n_chk  = 0;
        n_pass = 0;
        model_reset();
        #12;
        do_reset();

        // two lit digits, scan wraps twice
        wr(3'd0, 4'h1, 1'b0, 1'b1, 1'b0);
        wr(3'd1, 4'h0, 1'b0, 1'b1, 1'b0);
        run(2 * N * TICK + 4);

        // out-of-range addresses
        wr(3'd6, 4'h5, 1'b0, 1'b1, 1'b0);
        wr(3'd7, 4'h9, 1'b1, 1'b1, 1'b0);
        run(TICK);

        // clear collides with write; clear held during busy
        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 4'h5;
        wr_show  = 1'b1;
        step();
        wr_valid = 1'b0;
        run(3);
        clr_req = 1'b0;
        run(N * TICK);

        // blink, then blink with decimal point
        wr(3'd2, 4'h8, 1'b0, 1'b1, 1'b1);
        run(6 * N * TICK);
        wr(3'd2, 4'h8, 1'b1, 1'b1, 1'b1);
        run(6 * N * TICK);

        // reset while a digit is lit
        lit = 1'b0;
        for (int i = 0; i < 4 * N * TICK && !lit; i++) begin
            step();
            exp_out(k + 1, es, ed);
            lit = (ed != '0) && (es != 8'hFF);
        end
        chk("lit_seen", 32'(lit), 32'h1);
        do_reset();
        run(N * TICK);

        // reset in the middle of a clear
        wr(3'd3, 4'hA, 1'b0, 1'b1, 1'b0);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        run(2);
        do_reset();
        run(TICK);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            clr_req  = ($urandom_range(0, 99) < 3);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 4'($urandom_range(0, 15));
            wr_dp    = 1'($urandom_range(0, 1));
            wr_show  = ($urandom_range(0, 3) != 0);
            wr_blink = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            else step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
